// File: rtl/pe_mac_stream.sv
// Systolic-array processing element. It forwards data, tap, valid and last one hop per cycle.
// It multiply-accumulates one dot product per last-delimited burst, with optional saturation.
// Finished sums are queued in a 2-entry result FIFO that is drained by a valid/ready handshake.
module pe_mac_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_tap,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_data_t,
    output logic [DATA_WIDTH-1:0] o_tap_t,
    output logic                  o_valid_t,
    output logic                  o_last_t,
    output logic [ACC_WIDTH-1:0]  o_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_sat,
    output logic                  o_ovf
);

    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StAccum = 1'b1;

    logic [DATA_WIDTH-1:0] data_t_q, tap_t_q;
    logic                  valid_t_q, last_t_q;

    logic [0:0]            state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_base;

    logic signed [ProdWidth-1:0] prod_full;
    logic [ACC_WIDTH-1:0]        prod_acc;
    logic                        prod_clip;
    logic [ACC_WIDTH:0]          sum_wide;
    logic [ACC_WIDTH-1:0]        sum_acc;
    logic                        sum_clip;
    logic                        push;

    logic [ACC_WIDTH-1:0] mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           cnt_q;
    logic                 pop, full, push_ok, drop;
    logic                 sat_q, ovf_q;

    // Forwarding stage: data/tap always advance, tags are dropped on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_t_q  <= '0;
            tap_t_q   <= '0;
            valid_t_q <= 1'b0;
            last_t_q  <= 1'b0;
        end else begin
            data_t_q  <= i_data;
            tap_t_q   <= i_tap;
            valid_t_q <= i_valid & ~i_clr;
            last_t_q  <= i_last & i_valid & ~i_clr;
        end
    end

    assign prod_full = $signed(data_t_q) * $signed(tap_t_q);

    if (ACC_WIDTH >= ProdWidth) begin : g_prod_wide
        // Product always fits; sign-extend.
        assign prod_acc  = ACC_WIDTH'(prod_full);
        assign prod_clip = 1'b0;
    end else begin : g_prod_narrow
        logic prod_fits;
        // Fits when every bit above the accumulator sign bit matches it.
        assign prod_fits = (&prod_full[ProdWidth-1:ACC_WIDTH-1]) |
                           (~|prod_full[ProdWidth-1:ACC_WIDTH-1]);
        assign prod_clip = SATURATE && !prod_fits;
        assign prod_acc  = prod_clip ? (prod_full[ProdWidth-1] ? AccMin : AccMax)
                                     : prod_full[ACC_WIDTH-1:0];
    end

    // Sum with one guard bit; signed overflow when the top two bits disagree.
    always_comb begin
        acc_base = (state_q == StIdle) ? '0 : acc_q;
        sum_wide = {acc_base[ACC_WIDTH-1], acc_base} + {prod_acc[ACC_WIDTH-1], prod_acc};
        sum_clip = SATURATE && (sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1]);
        sum_acc  = sum_clip ? (sum_wide[ACC_WIDTH] ? AccMin : AccMax) : sum_wide[ACC_WIDTH-1:0];
    end

    // Accumulator FSM next state: accumulate on a plain term, push and restart on last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (i_clr) begin
            state_d = StIdle;
            acc_d   = '0;
        end else if (valid_t_q) begin
            if (last_t_q) begin
                push    = 1'b1;
                state_d = StIdle;
                acc_d   = '0;
            end else begin
                state_d = StAccum;
                acc_d   = sum_acc;
            end
        end
    end

    // Accumulator FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    assign pop     = (cnt_q != 2'd0) & i_result_ready;
    assign full    = (cnt_q == 2'd2);
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Result FIFO: a pop frees a slot for a push in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (i_clr) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= sum_acc;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky saturation and overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (i_clr) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (valid_t_q && (prod_clip || sum_clip)) begin
                sat_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_data_t       = data_t_q;
    assign o_tap_t        = tap_t_q;
    assign o_valid_t      = valid_t_q;
    assign o_last_t       = last_t_q;
    assign o_result       = mem_q[rd_ptr_q];
    assign o_result_valid = (cnt_q != 2'd0);
    assign o_sat          = sat_q;
    assign o_ovf          = ovf_q;

endmodule
